// File: rtl/serial_logical_op.sv
// Slice-serial logical operator: scans two N-bit operands W bits per cycle, LSB first,
// builds a nonzero flag for each, and returns one logical result of the two flags.
module serial_logical_op #(
  parameter int N = 8,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         c,
  output logic         op_err,
  output logic         busy
);

  localparam int S  = (W > 0) ? N / W : 1;
  localparam int CW = (S > 1) ? $clog2(S) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(S - 1);

  if (N < 1 || W < 1 || (N % W) != 0) begin : g_param_check
    $error("serial_logical_op: N must be >= 1 and a multiple of W");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Result table; reserved codes force c=0 and raise the error flag ({err, c}).
  function automatic logic [1:0] eval_op(input logic fa, input logic fb, input logic [2:0] code);
    logic [1:0] r;
    case (code)
      3'd0:    r = {1'b0, fa & fb};
      3'd1:    r = {1'b0, fa | fb};
      3'd2:    r = {1'b0, fa ^ fb};
      3'd3:    r = {1'b0, ~(fa & fb)};
      3'd4:    r = {1'b0, ~(fa | fb)};
      3'd5:    r = {1'b0, ~(fa ^ fb)};
      default: r = {1'b1, 1'b0};
    endcase
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic            fa_q, fa_d, fb_q, fb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            c_q, c_d, op_err_q, op_err_d;
  logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
  logic [W-1:0]    slice_a_s, slice_b_s;
  logic            fa_n_s, fb_n_s;
  logic [1:0]      res_s;

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    fa_d        = fa_q;
    fb_d        = fb_q;
    cnt_d       = cnt_q;
    c_d         = c_q;
    op_err_d    = op_err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    slice_a_s   = a_q[int'(cnt_q)*W +: W];
    slice_b_s   = b_q[int'(cnt_q)*W +: W];
    fa_n_s      = fa_q | (|slice_a_s);
    fb_n_s      = fb_q | (|slice_b_s);
    res_s       = eval_op(fa_n_s, fb_n_s, op_q);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          op_d       = op;
          fa_d       = 1'b0;
          fb_d       = 1'b0;
          cnt_d      = '0;
          state_d    = SCAN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        fa_d  = fa_n_s;
        fb_d  = fb_n_s;
        cnt_d = cnt_q + CW'(1);
        // Flags only ever rise, so once both are set the rest of the scan is moot.
        if ((fa_n_s & fb_n_s) || (cnt_q == LAST_SLICE)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          c_d         = res_s[0];
          op_err_d    = res_s[1];
        end else begin
          state_d = SCAN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 3'd0;
      fa_q        <= 1'b0;
      fb_q        <= 1'b0;
      cnt_q       <= '0;
      c_q         <= 1'b0;
      op_err_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      fa_q        <= fa_d;
      fb_q        <= fb_d;
      cnt_q       <= cnt_d;
      c_q         <= c_d;
      op_err_q    <= op_err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign op_err    = op_err_q;
  assign busy      = busy_q;

endmodule
